// File: rtl/mdu_div_seq_pkg.sv
// Shared MDU divider definitions: micro-op encoding, sequencer states and
// op-classification helpers used by the divider and its bench.
package mdu_div_seq_pkg;

    typedef enum logic [4:0] {
        MDU_NONE   = 5'd0,
        MDU_MUL    = 5'd1,
        MDU_MULH   = 5'd2,
        MDU_MULHSU = 5'd3,
        MDU_MULHU  = 5'd4,
        MDU_MULW   = 5'd5,
        MDU_DIV    = 5'd6,
        MDU_DIVW   = 5'd7,
        MDU_DIVU   = 5'd8,
        MDU_REM    = 5'd9,
        MDU_REMW   = 5'd10,
        MDU_REMU   = 5'd11,
        MDU_REMUW  = 5'd12
    } MicOp_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } DivState_t;

    function automatic logic is_div_op(MicOp_t op);
        return op inside {MDU_DIV, MDU_DIVW, MDU_DIVU, MDU_REM, MDU_REMW, MDU_REMU, MDU_REMUW};
    endfunction

    function automatic logic is_word_div(MicOp_t op);
        return op inside {MDU_DIVW, MDU_REMW, MDU_REMUW};
    endfunction

    function automatic logic is_signed_div(MicOp_t op);
        return op inside {MDU_DIV, MDU_DIVW, MDU_REM, MDU_REMW};
    endfunction

    function automatic logic is_rem(MicOp_t op);
        return op inside {MDU_REM, MDU_REMW, MDU_REMU, MDU_REMUW};
    endfunction

endpackage

// File: rtl/mdu_div_seq_if.sv
// Issue-slot and writeback handshake bundle of the MDU divider.
interface mdu_div_seq_if #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ROBIDX_W = 7,
    parameter int unsigned PRIDX_W  = 7
) ();
    logic                i_vld;
    logic                o_rdy;
    logic [4:0]          i_micop;
    logic [XLEN-1:0]     i_src0;
    logic [XLEN-1:0]     i_src1;
    logic [ROBIDX_W-1:0] i_robIdx;
    logic [PRIDX_W-1:0]  i_rd;
    logic                o_vld;
    logic                i_wb_rdy;
    logic [ROBIDX_W-1:0] o_robIdx;
    logic [PRIDX_W-1:0]  o_rd;
    logic [XLEN-1:0]     o_data;

    modport slave (
        input  i_vld, i_micop, i_src0, i_src1, i_robIdx, i_rd, i_wb_rdy,
        output o_rdy, o_vld, o_robIdx, o_rd, o_data
    );

    modport master (
        output i_vld, i_micop, i_src0, i_src1, i_robIdx, i_rd, i_wb_rdy,
        input  o_rdy, o_vld, o_robIdx, o_rd, o_data
    );
endinterface

// File: rtl/mdu_div_seq_step.sv
// One restoring-division iteration: shift {rem,quo}, trial subtract, quotient bit.
module mdu_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < dvs holds between steps, so the extra top bit is a clean borrow flag
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        diff    = shifted - {1'b0, dvs_i};
        rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
    end
endmodule

// File: rtl/mdu_div_seq.sv
// Iterative radix-2 divider sequencer of the MDU: accepts one div/rem op,
// resolves special cases, iterates, applies signs and holds the result for writeback.
module mdu_div_seq
    import mdu_div_seq_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ROBIDX_W = 7,
    parameter int unsigned PRIDX_W  = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    mdu_div_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    DivState_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    MicOp_t              op_q, op_d;
    logic [ROBIDX_W-1:0] rob_q, rob_d;
    logic [PRIDX_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]     src0_q, src0_d, src1_q, src1_d;
    logic [XLEN-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, data_q, data_d;
    logic                negq_q, negq_d, negr_q, negr_d;

    logic            word, sgn, rem_sel, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, smin, dext;
    logic [XLEN-1:0] q_sgn, r_sgn, sel, fix_res, spec_res;
    logic [XLEN-1:0] step_rem, step_quo;
    logic            rdy, accept;
    MicOp_t          op_in;

    always_comb begin
        word    = is_word_div(op_q);
        sgn     = is_signed_div(op_q);
        rem_sel = is_rem(op_q);
        dext    = word ? {{(XLEN-32){src0_q[31]}}, src0_q[31:0]} : src0_q;
        a_ext   = src0_q;
        b_ext   = src1_q;
        if (word) begin
            a_ext = sgn ? dext : {{(XLEN-32){1'b0}}, src0_q[31:0]};
            b_ext = sgn ? {{(XLEN-32){src1_q[31]}}, src1_q[31:0]}
                        : {{(XLEN-32){1'b0}}, src1_q[31:0]};
        end
        a_neg = sgn & a_ext[XLEN-1];
        b_neg = sgn & b_ext[XLEN-1];
        a_abs = a_neg ? -a_ext : a_ext;
        b_abs = b_neg ? -b_ext : b_ext;
        // Most negative W-bit value, viewed after sign extension to XLEN
        smin          = '0;
        smin[XLEN-1]  = 1'b1;
        if (word) smin[XLEN-1:31] = '1;
        div0     = (b_ext == '0);
        ovf      = sgn && (a_ext == smin) && (b_ext == '1);
        spec_res = rem_sel ? (div0 ? dext : '0) : (div0 ? '1 : dext);
        q_sgn    = negq_q ? -quo_q : quo_q;
        r_sgn    = negr_q ? -rem_q : rem_q;
        sel      = rem_sel ? r_sgn : q_sgn;
        fix_res  = word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    end

    mdu_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        op_in   = MicOp_t'(bus.i_micop);
        rdy     = (state_q == IDLE) && !i_flush;
        accept  = bus.i_vld && rdy && is_div_op(op_in);
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rob_d   = rob_q;
        rd_d    = rd_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        data_d  = data_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    rob_d   = bus.i_robIdx;
                    rd_d    = bus.i_rd;
                    src0_d  = bus.i_src0;
                    src1_d  = bus.i_src1;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (div0 || ovf) begin
                    data_d  = spec_res;
                    state_d = DONE;
                end else begin
                    // Word dividends are left-aligned so the top quotient bit comes out first
                    quo_d   = word ? (a_abs << 32) : a_abs;
                    rem_d   = '0;
                    dvs_d   = b_abs;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    cnt_d   = word ? CNT_W'(31) : CNT_W'(XLEN-1);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                data_d  = fix_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.i_wb_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            rob_q   <= '0;
            rd_q    <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            data_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rob_q   <= rob_d;
            rd_q    <= rd_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            data_q  <= data_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && bus.i_vld && rdy) begin
            assert (is_div_op(op_in));
        end
    end

    assign bus.o_rdy    = rdy;
    assign bus.o_vld    = (state_q == DONE);
    assign bus.o_data   = data_q;
    assign bus.o_robIdx = rob_q;
    assign bus.o_rd     = rd_q;
endmodule
